// File: rtl/pcap_record_aligner.sv
// pcap_record_aligner: splits a PCAP record stream (global header removed)
// into per-record header sideband and payload realigned to byte lane 0.
// Input bytes are queued in a 2*DATA_BYTES byte buffer. Each record header
// may start at any byte offset. Payload leaves through a registered AXI-stream
// style output with TKEEP/TLAST/SOP framing.
module pcap_record_aligner #(
    parameter int DATA_BYTES   = 16,
    parameter int MAX_INCL_LEN = 9600,
    parameter int CNT_W        = 32
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    SWAP,
    input  logic                    S_TVALID,
    output logic                    S_TREADY,
    input  logic [8*DATA_BYTES-1:0] S_TDATA,
    input  logic [DATA_BYTES-1:0]   S_TKEEP,
    input  logic                    S_TLAST,
    output logic                    M_TVALID,
    input  logic                    M_TREADY,
    output logic [8*DATA_BYTES-1:0] M_TDATA,
    output logic [DATA_BYTES-1:0]   M_TKEEP,
    output logic                    M_TLAST,
    output logic                    M_SOP,
    output logic [31:0]             HDR_TS_SEC,
    output logic [31:0]             HDR_TS_FRAC,
    output logic [31:0]             HDR_INCL_LEN,
    output logic [31:0]             HDR_ORIG_LEN,
    output logic                    HDR_VALID,
    output logic [CNT_W-1:0]        RECORD_CNT,
    output logic                    ERR_FORMAT,
    output logic                    ERR_TRUNC
);

    localparam int BUF_BYTES = 2 * DATA_BYTES;
    localparam int OCC_W     = $clog2(BUF_BYTES) + 1;
    localparam int HDR_BYTES = 16;
    localparam logic [OCC_W-1:0] DB_OCC  = OCC_W'(DATA_BYTES);
    localparam logic [OCC_W-1:0] HDR_OCC = OCC_W'(HDR_BYTES);

    typedef enum logic [1:0] {ST_HDR, ST_PAYLOAD, ST_DRAIN, ST_ERROR} state_t;

    state_t           state_q, state_d;
    logic [7:0]       byte_q [BUF_BYTES];
    logic [7:0]       byte_d [BUF_BYTES];
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [31:0]      rem_q;
    logic             eof_q;
    logic             run_q;

    logic             out_free, hdr_fire, hdr_bad, hdr_trunc, hdr_done;
    logic             pay_fire, trunc_fire, load_out, push;
    logic [OCC_W-1:0] n_bytes, pop_cnt, emit_cnt, push_cnt;
    logic [31:0]      f_ts_sec, f_ts_frac, f_incl, f_orig;
    logic [8*DATA_BYTES-1:0] out_data;
    logic [DATA_BYTES-1:0]   out_keep;

    // Assemble one 32-bit header field from four buffered bytes.
    function automatic logic [31:0] field32(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3,
                                            input logic sw);
        return sw ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
    endfunction

    assign f_ts_sec  = field32(byte_q[0],  byte_q[1],  byte_q[2],  byte_q[3],  SWAP);
    assign f_ts_frac = field32(byte_q[4],  byte_q[5],  byte_q[6],  byte_q[7],  SWAP);
    assign f_incl    = field32(byte_q[8],  byte_q[9],  byte_q[10], byte_q[11], SWAP);
    assign f_orig    = field32(byte_q[12], byte_q[13], byte_q[14], byte_q[15], SWAP);
    assign hdr_bad   = (f_incl == 32'd0) || (f_incl > 32'(MAX_INCL_LEN));

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: every sequential block uses non-blocking assignments so all flops see pre-edge values.
        if (!RST_N) state_q <= ST_HDR;
        else        state_q <= state_d;
    end

    // Per-cycle decisions: header latch, payload beat, truncation, pop size and input ready.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        out_free   = !M_TVALID || M_TREADY;
        n_bytes    = (rem_q < 32'(DATA_BYTES)) ? rem_q[OCC_W-1:0] : DB_OCC;
        hdr_fire   = 1'b0;
        hdr_trunc  = 1'b0;
        hdr_done   = 1'b0;
        pay_fire   = 1'b0;
        trunc_fire = 1'b0;
        pop_cnt    = '0;
        emit_cnt   = '0;
        unique case (state_q)
            ST_HDR: begin
                if (occ_q >= HDR_OCC) begin
                    hdr_fire = 1'b1;
                    pop_cnt  = HDR_OCC;
                end else if (eof_q) begin
                    hdr_trunc = (occ_q != '0);
                    hdr_done  = (occ_q == '0);
                end
            end
            ST_PAYLOAD: begin
                if (out_free) begin
                    if (occ_q >= n_bytes) begin
                        pay_fire = 1'b1;
                        pop_cnt  = n_bytes;
                        emit_cnt = n_bytes;
                    end else if (eof_q) begin
                        trunc_fire = 1'b1;
                        pop_cnt    = occ_q;
                        emit_cnt   = occ_q;
                    end
                end
            end
            default: ;
        endcase
        load_out = pay_fire || (trunc_fire && (occ_q != '0));
        S_TREADY = run_q && !eof_q && ((state_q == ST_HDR) || (state_q == ST_PAYLOAD)) &&
                   ((occ_q - pop_cnt) <= DB_OCC);
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_HDR: begin
                if (hdr_fire)       state_d = hdr_bad ? ST_ERROR : ST_PAYLOAD;
                else if (hdr_trunc) state_d = ST_ERROR;
                else if (hdr_done)  state_d = ST_DRAIN;
            end
            ST_PAYLOAD: begin
                if (pay_fire && (32'(n_bytes) == rem_q)) state_d = ST_HDR;
                else if (trunc_fire)                     state_d = ST_DRAIN;
            end
            default: ;
        endcase
    end

    // Next buffer contents: shift out popped bytes, append accepted bytes behind the survivors.
    always_comb begin
        push     = S_TVALID && S_TREADY;
        push_cnt = '0;
        for (int j = 0; j < DATA_BYTES; j++) push_cnt = push_cnt + OCC_W'(S_TKEEP[j]);
        for (int i = 0; i < BUF_BYTES; i++) begin
            byte_d[i] = 8'h00;
            if (i + int'(pop_cnt) < BUF_BYTES) byte_d[i] = byte_q[i + int'(pop_cnt)];
        end
        if (push) begin
            for (int j = 0; j < DATA_BYTES; j++) begin
                if (S_TKEEP[j] && (int'(occ_q - pop_cnt) + j < BUF_BYTES))
                    byte_d[int'(occ_q - pop_cnt) + j] = S_TDATA[8*j +: 8];
            end
        end
        occ_d = occ_q - pop_cnt + (push ? push_cnt : '0);
    end

    // Output beat contents: first emit_cnt buffered bytes, unused lanes zeroed.
    always_comb begin
        out_data = '0;
        out_keep = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (OCC_W'(i) < emit_cnt) begin
                out_data[8*i +: 8] = byte_q[i];
                out_keep[i]        = 1'b1;
            end
        end
    end

    // Byte buffer, occupancy, end-of-file flag and post-reset ready enable.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: the buffer is a small flop array, cleared so no stale bytes survive a reset.
            for (int i = 0; i < BUF_BYTES; i++) byte_q[i] <= 8'h00;
            occ_q <= '0;
            eof_q <= 1'b0;
            run_q <= 1'b0;
        end else begin
            for (int i = 0; i < BUF_BYTES; i++) byte_q[i] <= byte_d[i];
            occ_q <= occ_d;
            eof_q <= eof_q || (push && S_TLAST);
            run_q <= 1'b1;
        end
    end

    // Header sideband, record counter, remaining payload count and sticky errors.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            HDR_TS_SEC   <= '0;
            HDR_TS_FRAC  <= '0;
            HDR_INCL_LEN <= '0;
            HDR_ORIG_LEN <= '0;
            HDR_VALID    <= 1'b0;
            RECORD_CNT   <= '0;
            rem_q        <= '0;
            ERR_FORMAT   <= 1'b0;
            ERR_TRUNC    <= 1'b0;
        end else begin
            HDR_VALID <= hdr_fire;
            if (hdr_fire) begin
                HDR_TS_SEC   <= f_ts_sec;
                HDR_TS_FRAC  <= f_ts_frac;
                HDR_INCL_LEN <= f_incl;
                HDR_ORIG_LEN <= f_orig;
                RECORD_CNT   <= RECORD_CNT + 1'b1;
                rem_q        <= f_incl;
                if (hdr_bad) ERR_FORMAT <= 1'b1;
            end else if (pay_fire || trunc_fire) begin
                rem_q <= rem_q - 32'(emit_cnt);
            end
            if (hdr_trunc || trunc_fire) ERR_TRUNC <= 1'b1;
        end
    end

    // Output register: load a new beat when free, otherwise hold until accepted.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            M_TVALID <= 1'b0;
            M_TDATA  <= '0;
            M_TKEEP  <= '0;
            M_TLAST  <= 1'b0;
            M_SOP    <= 1'b0;
        end else if (load_out) begin
            M_TVALID <= 1'b1;
            M_TDATA  <= out_data;
            M_TKEEP  <= out_keep;
            M_TLAST  <= trunc_fire || (32'(n_bytes) == rem_q);
            M_SOP    <= (rem_q == HDR_INCL_LEN);
        end else if (M_TREADY) begin
            M_TVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pcap_record_aligner.sv
// Directed bench for pcap_record_aligner: main instance at 16-byte beats,
// plus 8- and 64-byte instances replaying the basic record.
module tb_pcap_record_aligner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 16-byte instance
    logic         swap_in;
    logic         s_tvalid, s_tready, s_tlast;
    logic [127:0] s_tdata;
    logic [15:0]  s_tkeep;
    logic         m_tvalid, m_tready, m_tlast, m_sop;
    logic [127:0] m_tdata;
    logic [15:0]  m_tkeep;
    logic [31:0]  hdr_ts_sec, hdr_ts_frac, hdr_incl_len, hdr_orig_len;
    logic         hdr_valid;
    logic [31:0]  record_cnt;
    logic         err_format, err_trunc;

    // 8-byte instance
    logic         s8_tvalid, s8_tready, s8_tlast, m8_tvalid, m8_tlast, m8_sop, hv8, ef8, et8;
    logic [63:0]  s8_tdata, m8_tdata;
    logic [7:0]   s8_tkeep, m8_tkeep;
    logic [31:0]  a8, b8, c8, d8, cnt8;

    // 64-byte instance
    logic         s64_tvalid, s64_tready, s64_tlast, m64_tvalid, m64_tlast, m64_sop, hv64, ef64, et64;
    logic [511:0] s64_tdata, m64_tdata;
    logic [63:0]  s64_tkeep, m64_tkeep;
    logic [31:0]  a64, b64, c64, d64, cnt64;

    pcap_record_aligner #(.DATA_BYTES(16), .MAX_INCL_LEN(9600), .CNT_W(32)) dut (
        .CLK(clk), .RST_N(rst_n), .SWAP(swap_in),
        .S_TVALID(s_tvalid), .S_TREADY(s_tready), .S_TDATA(s_tdata), .S_TKEEP(s_tkeep), .S_TLAST(s_tlast),
        .M_TVALID(m_tvalid), .M_TREADY(m_tready), .M_TDATA(m_tdata), .M_TKEEP(m_tkeep), .M_TLAST(m_tlast),
        .M_SOP(m_sop), .HDR_TS_SEC(hdr_ts_sec), .HDR_TS_FRAC(hdr_ts_frac), .HDR_INCL_LEN(hdr_incl_len),
        .HDR_ORIG_LEN(hdr_orig_len), .HDR_VALID(hdr_valid), .RECORD_CNT(record_cnt),
        .ERR_FORMAT(err_format), .ERR_TRUNC(err_trunc));

    pcap_record_aligner #(.DATA_BYTES(8), .MAX_INCL_LEN(9600), .CNT_W(32)) dut8 (
        .CLK(clk), .RST_N(rst_n), .SWAP(1'b0),
        .S_TVALID(s8_tvalid), .S_TREADY(s8_tready), .S_TDATA(s8_tdata), .S_TKEEP(s8_tkeep), .S_TLAST(s8_tlast),
        .M_TVALID(m8_tvalid), .M_TREADY(1'b1), .M_TDATA(m8_tdata), .M_TKEEP(m8_tkeep), .M_TLAST(m8_tlast),
        .M_SOP(m8_sop), .HDR_TS_SEC(a8), .HDR_TS_FRAC(b8), .HDR_INCL_LEN(c8), .HDR_ORIG_LEN(d8),
        .HDR_VALID(hv8), .RECORD_CNT(cnt8), .ERR_FORMAT(ef8), .ERR_TRUNC(et8));

    pcap_record_aligner #(.DATA_BYTES(64), .MAX_INCL_LEN(9600), .CNT_W(32)) dut64 (
        .CLK(clk), .RST_N(rst_n), .SWAP(1'b0),
        .S_TVALID(s64_tvalid), .S_TREADY(s64_tready), .S_TDATA(s64_tdata), .S_TKEEP(s64_tkeep), .S_TLAST(s64_tlast),
        .M_TVALID(m64_tvalid), .M_TREADY(1'b1), .M_TDATA(m64_tdata), .M_TKEEP(m64_tkeep), .M_TLAST(m64_tlast),
        .M_SOP(m64_sop), .HDR_TS_SEC(a64), .HDR_TS_FRAC(b64), .HDR_INCL_LEN(c64), .HDR_ORIG_LEN(d64),
        .HDR_VALID(hv64), .RECORD_CNT(cnt64), .ERR_FORMAT(ef64), .ERR_TRUNC(et64));

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         sop;
        logic         last;
    } beat_t;

    beat_t      beats[$];
    logic [7:0] file_b[$];
    logic [7:0] exp_b[$];
    logic [7:0] got_b[$];
    int         hdr_pulses;
    int         checks = 0;
    int         errors = 0;

    // ---------------- stimulus helpers (no comparisons) ----------------
    task automatic add_hdr(input logic [31:0] sec, input logic [31:0] frac,
                           input logic [31:0] incl, input logic [31:0] orig, input bit sw);
        logic [31:0] f[4];
        f[0] = sec; f[1] = frac; f[2] = incl; f[3] = orig;
        for (int k = 0; k < 4; k++)
            for (int b = 0; b < 4; b++)
                file_b.push_back(sw ? f[k][8*(3-b) +: 8] : f[k][8*b +: 8]);
    endtask

    task automatic add_payload(input int start, input int step, input int len);
        for (int i = 0; i < len; i++) begin
            file_b.push_back(8'((start + i * step) & 255));
            exp_b.push_back(8'((start + i * step) & 255));
        end
    endtask

    task automatic flatten();
        got_b.delete();
        foreach (beats[i])
            for (int j = 0; j < 16; j++)
                if (beats[i].keep[j]) got_b.push_back(beats[i].data[8*j +: 8]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_tvalid = 0; s_tlast = 0; s_tdata = '0; s_tkeep = '0; m_tready = 1; swap_in = 0;
        s8_tvalid = 0; s8_tlast = 0; s8_tdata = '0; s8_tkeep = '0;
        s64_tvalid = 0; s64_tlast = 0; s64_tdata = '0; s64_tkeep = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        beats.delete(); file_b.delete(); exp_b.delete(); got_b.delete();
        hdr_pulses = 0;
    endtask

    // Drives file_b as 16-byte beats; inputs change on negedge, handshake sampled 1 before posedge.
    task automatic drive_file(input bit gap, input int budget, output bit done);
        int pos;
        int cyc;
        pos = 0; cyc = 0;
        while (pos < file_b.size() && cyc < budget) begin
            @(negedge clk);
            s_tdata = '0; s_tkeep = '0;
            for (int j = 0; j < 16; j++)
                if (pos + j < file_b.size()) begin
                    s_tdata[8*j +: 8] = file_b[pos + j];
                    s_tkeep[j] = 1'b1;
                end
            s_tlast  = (pos + 16 >= file_b.size());
            s_tvalid = !(gap && ($urandom_range(0, 2) == 0));
            #4;
            if (s_tvalid && s_tready) pos += 16;
            cyc++;
        end
        @(negedge clk);
        s_tvalid = 0; s_tlast = 0;
        done = (pos >= file_b.size());
    endtask

    // Collects output beats until n_last TLASTs, checking that stalled beats hold still.
    task automatic collect(input int n_last, input bit rand_ready, input int budget);
        int    lasts;
        int    cyc;
        bit    stalled;
        beat_t held;
        beat_t cur;
        lasts = 0; cyc = 0; stalled = 0;
        held = '{data: '0, keep: '0, sop: 1'b0, last: 1'b0};
        while (lasts < n_last && cyc < budget) begin
            @(negedge clk);
            m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #4;
            if (hdr_valid) hdr_pulses++;
            cur = '{data: m_tdata, keep: m_tkeep, sop: m_sop, last: m_tlast};
            if (stalled) begin
                checks++;
                if (m_tvalid !== 1'b1 || cur.data !== held.data || cur.keep !== held.keep ||
                    cur.sop !== held.sop || cur.last !== held.last) begin
                    errors++;
                    $display("FAIL stall_hold got valid=%b keep=%h want valid=1 keep=%h (held)", m_tvalid, cur.keep, held.keep);
                end
            end
            stalled = m_tvalid && !m_tready;
            held = cur;
            if (m_tvalid && m_tready) begin
                beats.push_back(cur);
                if (m_tlast) lasts++;
            end
            cyc++;
        end
        checks++;
        if (lasts < n_last) begin
            errors++;
            $display("FAIL collect_timeout got %0d records want %0d", lasts, n_last);
        end
        @(negedge clk);
        m_tready = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        s_tvalid = 0; m_tready = 1; swap_in = 0;
        s8_tvalid = 0; s64_tvalid = 0;
        #3;
        checks++; if (m_tvalid !== 1'b0)    begin errors++; $display("FAIL rst_m_tvalid got %b want 0", m_tvalid); end
        checks++; if (s_tready !== 1'b0)    begin errors++; $display("FAIL rst_s_tready got %b want 0", s_tready); end
        checks++; if (record_cnt !== 32'd0) begin errors++; $display("FAIL rst_record_cnt got %0d want 0", record_cnt); end
        checks++; if (hdr_valid !== 1'b0 || err_format !== 1'b0 || err_trunc !== 1'b0)
                  begin errors++; $display("FAIL rst_flags got %b%b%b want 000", hdr_valid, err_format, err_trunc); end
        checks++; if (m_tkeep !== 16'h0 || hdr_incl_len !== 32'h0)
                  begin errors++; $display("FAIL rst_fields got keep=%h incl=%h want 0", m_tkeep, hdr_incl_len); end
        do_reset();
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b want 1", s_tready); end
    endtask

    task automatic test_basic(input bit sw);
        bit done;
        do_reset();
        swap_in = sw;
        add_hdr(32'd5, 32'd7, 32'd64, 32'd64, sw);
        add_payload(0, 1, 64);
        fork
            drive_file(1'b0, 200, done);
            collect(1, 1'b0, 200);
        join
        flatten();
        checks++; if (!done) begin errors++; $display("FAIL basic%0d_input got incomplete want complete", sw); end
        checks++; if (beats.size() != 4) begin errors++; $display("FAIL basic%0d_beats got %0d want 4", sw, beats.size()); end
        foreach (beats[i]) begin
            checks++;
            if (beats[i].keep !== 16'hFFFF || beats[i].sop !== (i == 0) || beats[i].last !== (i == 3)) begin
                errors++;
                $display("FAIL basic%0d_frame beat %0d got keep=%h sop=%b last=%b want keep=ffff sop=%b last=%b",
                         sw, i, beats[i].keep, beats[i].sop, beats[i].last, i == 0, i == 3);
            end
        end
        checks++; if (got_b.size() != 64) begin errors++; $display("FAIL basic%0d_len got %0d want 64", sw, got_b.size()); end
        foreach (got_b[i]) if (i < exp_b.size()) begin
            checks++;
            if (got_b[i] !== exp_b[i]) begin errors++; $display("FAIL basic%0d_byte %0d got %h want %h", sw, i, got_b[i], exp_b[i]); end
        end
        checks++; if (hdr_ts_sec !== 32'd5)  begin errors++; $display("FAIL basic%0d_ts_sec got %0d want 5", sw, hdr_ts_sec); end
        checks++; if (hdr_ts_frac !== 32'd7) begin errors++; $display("FAIL basic%0d_ts_frac got %0d want 7", sw, hdr_ts_frac); end
        checks++; if (hdr_incl_len !== 32'd64 || hdr_orig_len !== 32'd64)
                  begin errors++; $display("FAIL basic%0d_lens got %0d/%0d want 64/64", sw, hdr_incl_len, hdr_orig_len); end
        checks++; if (record_cnt !== 32'd1) begin errors++; $display("FAIL basic%0d_count got %0d want 1", sw, record_cnt); end
        checks++; if (hdr_pulses != 1) begin errors++; $display("FAIL basic%0d_hdr_valid got %0d pulses want 1", sw, hdr_pulses); end
        checks++; if (err_format !== 1'b0 || err_trunc !== 1'b0)
                  begin errors++; $display("FAIL basic%0d_errs got %b%b want 00", sw, err_format, err_trunc); end
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL basic%0d_drain_ready got %b want 0", sw, s_tready); end
    endtask

    task automatic test_back_to_back();
        bit         done;
        logic [15:0] k_exp[3];
        bit          s_exp[3];
        bit          l_exp[3];
        k_exp = '{16'hFFFF, 16'h000F, 16'h1FFF};
        s_exp = '{1'b1, 1'b0, 1'b1};
        l_exp = '{1'b0, 1'b1, 1'b1};
        do_reset();
        add_hdr(32'd1, 32'd2, 32'd20, 32'd20, 1'b0);
        add_payload(0, 1, 20);
        add_hdr(32'd3, 32'd4, 32'd13, 32'd13, 1'b0);
        add_payload(8'hA0, 1, 13);
        fork
            drive_file(1'b0, 200, done);
            collect(2, 1'b0, 200);
        join
        flatten();
        checks++; if (beats.size() != 3) begin errors++; $display("FAIL b2b_beats got %0d want 3", beats.size()); end
        foreach (beats[i]) if (i < 3) begin
            checks++;
            if (beats[i].keep !== k_exp[i] || beats[i].sop !== s_exp[i] || beats[i].last !== l_exp[i]) begin
                errors++;
                $display("FAIL b2b_frame beat %0d got keep=%h sop=%b last=%b want keep=%h sop=%b last=%b",
                         i, beats[i].keep, beats[i].sop, beats[i].last, k_exp[i], s_exp[i], l_exp[i]);
            end
        end
        checks++; if (got_b.size() != 33) begin errors++; $display("FAIL b2b_len got %0d want 33", got_b.size()); end
        foreach (got_b[i]) if (i < exp_b.size()) begin
            checks++;
            if (got_b[i] !== exp_b[i]) begin errors++; $display("FAIL b2b_byte %0d got %h want %h", i, got_b[i], exp_b[i]); end
        end
        checks++; if (record_cnt !== 32'd2) begin errors++; $display("FAIL b2b_count got %0d want 2", record_cnt); end
        checks++; if (hdr_pulses != 2) begin errors++; $display("FAIL b2b_hdr_valid got %0d want 2", hdr_pulses); end
        checks++; if (hdr_ts_sec !== 32'd3 || hdr_incl_len !== 32'd13)
                  begin errors++; $display("FAIL b2b_hdr2 got sec=%0d incl=%0d want 3/13", hdr_ts_sec, hdr_incl_len); end
    endtask

    task automatic test_stall();
        bit done;
        do_reset();
        add_hdr(32'd9, 32'd9, 32'd100, 32'd100, 1'b0);
        add_payload(1, 3, 100);
        fork
            drive_file(1'b1, 1000, done);
            collect(1, 1'b1, 1000);
        join
        flatten();
        checks++; if (beats.size() != 7) begin errors++; $display("FAIL stall_beats got %0d want 7", beats.size()); end
        if (beats.size() == 7) begin
            checks++;
            if (beats[6].keep !== 16'h000F || beats[6].last !== 1'b1 || beats[0].sop !== 1'b1)
                begin errors++; $display("FAIL stall_frame got keep=%h last=%b sop0=%b want 000f/1/1", beats[6].keep, beats[6].last, beats[0].sop); end
        end
        checks++; if (got_b.size() != 100) begin errors++; $display("FAIL stall_len got %0d want 100", got_b.size()); end
        foreach (got_b[i]) if (i < exp_b.size()) begin
            checks++;
            if (got_b[i] !== exp_b[i]) begin errors++; $display("FAIL stall_byte %0d got %h want %h", i, got_b[i], exp_b[i]); end
        end
    endtask

    task automatic test_format(input logic [31:0] incl);
        bit done;
        int seen;
        do_reset();
        add_hdr(32'd1, 32'd1, incl, incl, 1'b0);
        add_payload(0, 1, 48);
        seen = 0;
        fork
            drive_file(1'b0, 40, done);
            for (int c = 0; c < 40; c++) begin
                @(negedge clk); #4;
                if (m_tvalid) seen++;
            end
        join
        checks++; if (seen != 0) begin errors++; $display("FAIL fmt_%0d_out got %0d valid cycles want 0", incl, seen); end
        checks++; if (err_format !== 1'b1) begin errors++; $display("FAIL fmt_%0d_err got %b want 1", incl, err_format); end
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL fmt_%0d_ready got %b want 0", incl, s_tready); end
        checks++; if (record_cnt !== 32'd1) begin errors++; $display("FAIL fmt_%0d_count got %0d want 1", incl, record_cnt); end
        do_reset();
        checks++; if (err_format !== 1'b0 || s_tready !== 1'b1)
                  begin errors++; $display("FAIL fmt_%0d_recover got err=%b ready=%b want 0/1", incl, err_format, s_tready); end
    endtask

    task automatic test_trunc();
        bit done;
        do_reset();
        add_hdr(32'd5, 32'd7, 32'd64, 32'd64, 1'b0);
        add_payload(0, 1, 10);
        fork
            drive_file(1'b0, 200, done);
            collect(1, 1'b0, 200);
        join
        flatten();
        checks++; if (beats.size() != 1) begin errors++; $display("FAIL trunc_beats got %0d want 1", beats.size()); end
        if (beats.size() == 1) begin
            checks++;
            if (beats[0].keep !== 16'h03FF || beats[0].last !== 1'b1 || beats[0].sop !== 1'b1)
                begin errors++; $display("FAIL trunc_frame got keep=%h last=%b sop=%b want 03ff/1/1", beats[0].keep, beats[0].last, beats[0].sop); end
        end
        foreach (got_b[i]) if (i < exp_b.size()) begin
            checks++;
            if (got_b[i] !== exp_b[i]) begin errors++; $display("FAIL trunc_byte %0d got %h want %h", i, got_b[i], exp_b[i]); end
        end
        checks++; if (err_trunc !== 1'b1 || err_format !== 1'b0)
                  begin errors++; $display("FAIL trunc_err got trunc=%b fmt=%b want 1/0", err_trunc, err_format); end
        checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL trunc_ready got %b want 0", s_tready); end
    endtask

    task automatic test_reset_mid();
        bit done;
        do_reset();
        add_hdr(32'd5, 32'd7, 32'd64, 32'd64, 1'b0);
        add_payload(0, 1, 64);
        m_tready = 1'b0;
        drive_file(1'b0, 8, done);
        checks++; if (m_tvalid !== 1'b1) begin errors++; $display("FAIL mid_pre got valid=%b want 1", m_tvalid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (m_tvalid !== 1'b0 || record_cnt !== 32'd0 || s_tready !== 1'b0)
                  begin errors++; $display("FAIL mid_rst got valid=%b cnt=%0d ready=%b want 0/0/0", m_tvalid, record_cnt, s_tready); end
        do_reset();
    endtask

    task automatic test_widths();
        logic [7:0] g8[$];
        logic [7:0] g64[$];
        int nb8, nb64;
        bit last8, last64;
        do_reset();
        add_hdr(32'd5, 32'd7, 32'd64, 32'd64, 1'b0);
        add_payload(0, 1, 64);
        nb8 = 0; nb64 = 0; last8 = 0; last64 = 0;
        fork
            begin
                int pos;
                pos = 0;
                for (int c = 0; c < 300 && pos < 80; c++) begin
                    @(negedge clk);
                    for (int j = 0; j < 8; j++) s8_tdata[8*j +: 8] = file_b[pos + j];
                    s8_tkeep = 8'hFF; s8_tlast = (pos + 8 >= 80); s8_tvalid = 1'b1;
                    #4; if (s8_tready) pos += 8;
                end
                @(negedge clk); s8_tvalid = 1'b0;
            end
            begin
                int pos;
                pos = 0;
                for (int c = 0; c < 300 && pos < 80; c++) begin
                    @(negedge clk);
                    s64_tdata = '0; s64_tkeep = '0;
                    for (int j = 0; j < 64; j++) if (pos + j < 80) begin
                        s64_tdata[8*j +: 8] = file_b[pos + j]; s64_tkeep[j] = 1'b1;
                    end
                    s64_tlast = (pos + 64 >= 80); s64_tvalid = 1'b1;
                    #4; if (s64_tready) pos += 64;
                end
                @(negedge clk); s64_tvalid = 1'b0;
            end
            for (int c = 0; c < 300 && !last8; c++) begin
                @(negedge clk); #4;
                if (m8_tvalid) begin
                    nb8++; last8 = m8_tlast;
                    for (int j = 0; j < 8; j++) if (m8_tkeep[j]) g8.push_back(m8_tdata[8*j +: 8]);
                end
            end
            for (int c = 0; c < 300 && !last64; c++) begin
                @(negedge clk); #4;
                if (m64_tvalid) begin
                    nb64++; last64 = m64_tlast;
                    for (int j = 0; j < 64; j++) if (m64_tkeep[j]) g64.push_back(m64_tdata[8*j +: 8]);
                end
            end
        join
        checks++; if (!last8 || nb8 != 8) begin errors++; $display("FAIL w8_beats got %0d last=%b want 8/1", nb8, last8); end
        checks++; if (!last64 || nb64 != 1) begin errors++; $display("FAIL w64_beats got %0d last=%b want 1/1", nb64, last64); end
        checks++; if (g8.size() != 64 || g64.size() != 64)
                  begin errors++; $display("FAIL w_len got %0d/%0d want 64/64", g8.size(), g64.size()); end
        foreach (g8[i]) if (i < exp_b.size()) begin
            checks++; if (g8[i] !== exp_b[i]) begin errors++; $display("FAIL w8_byte %0d got %h want %h", i, g8[i], exp_b[i]); end
        end
        foreach (g64[i]) if (i < exp_b.size()) begin
            checks++; if (g64[i] !== exp_b[i]) begin errors++; $display("FAIL w64_byte %0d got %h want %h", i, g64[i], exp_b[i]); end
        end
        checks++; if (cnt8 !== 32'd1 || cnt64 !== 32'd1)
                  begin errors++; $display("FAIL w_count got %0d/%0d want 1/1", cnt8, cnt64); end
    endtask

    initial begin
        test_reset();
        test_basic(1'b0);
        test_back_to_back();
        test_basic(1'b1);
        test_stall();
        test_format(32'd0);
        test_basic(1'b0);
        test_format(32'd9601);
        test_trunc();
        test_reset_mid();
        test_widths();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pcap_record_aligner.md
Name: pcap_record_aligner

Overview:
Parametrised successor to the fixed 128-bit local-header parser. It takes the PCAP byte stream after the global header has been stripped, in any beat width. It extracts each 16-byte record header at any byte alignment and emits the record payload realigned to byte lane 0, with TKEEP/TLAST framing and a per-record header sideband. It sits between the global-header parser and the FCS/packet stage, and replaces the aligned-only two-state local-header parser.

Parameters:
DATA_BYTES, 16, beat width in bytes on both streams; legal values 8, 16, 32, 64.
MAX_INCL_LEN, 9600, largest legal incl_len in bytes; larger values are a format error.
CNT_W, 32, width of the record counter.

Ports:
CLK  in  1  clock; all logic rising-edge.
RST_N  in  1  asynchronous active-low reset.
SWAP  in  1  1 = file is big-endian (swapped magic); sampled at each header latch.
S_TVALID  in  1  input beat valid.
S_TREADY  out  1  input beat accepted when S_TVALID&&S_TREADY.
S_TDATA  in  8*DATA_BYTES  input bytes, byte 0 in [7:0].
S_TKEEP  in  DATA_BYTES  contiguous-from-bit-0 byte enables; all ones except on the S_TLAST beat.
S_TLAST  in  1  end of file.
M_TVALID  out  1  output beat valid.
M_TREADY  in  1  downstream ready.
M_TDATA  out  8*DATA_BYTES  payload bytes, lane 0 first.
M_TKEEP  out  DATA_BYTES  contiguous byte enables.
M_TLAST  out  1  last beat of a record.
M_SOP  out  1  first beat of a record.
HDR_TS_SEC  out  32  ts_sec of the current record.
HDR_TS_FRAC  out  32  ts_usec/ts_nsec of the current record.
HDR_INCL_LEN  out  32  incl_len of the current record.
HDR_ORIG_LEN  out  32  orig_len of the current record.
HDR_VALID  out  1  single-cycle pulse when the header fields update.
RECORD_CNT  out  CNT_W  headers latched since reset; wraps.
ERR_FORMAT  out  1  sticky: incl_len==0 or incl_len>MAX_INCL_LEN.
ERR_TRUNC  out  1  sticky: file ended inside a header or payload.

Behaviour:
- Reset values: all outputs 0, state HDR, buffer occupancy 0, remaining 0.
- Buffer: byte buffer of 2*DATA_BYTES with occupancy occ. An accepted beat appends popcount(S_TKEEP) bytes at offset occ.
- S_TREADY = (occ - pop_this_cycle <= DATA_BYTES) && state != ERROR && !eof_seen. It is combinational from registered state and the pop decision, never from S_TVALID.
- Push and pop in the same cycle are both applied. Occupancy never exceeds 2*DATA_BYTES.
- States: HDR, PAYLOAD, DRAIN, ERROR.
- HDR, when occ>=16:
  - Latch bytes 0-15 as ts_sec, ts_frac, incl_len, orig_len, each little-endian 32-bit. If SWAP=1, byte-reverse each field.
  - Pop 16 bytes. Pulse HDR_VALID, RECORD_CNT+1, remaining<=incl_len.
  - If incl_len==0 or >MAX_INCL_LEN: set ERR_FORMAT and go to ERROR; the record is still counted.
  - Otherwise go to PAYLOAD.
- PAYLOAD: n = min(remaining, DATA_BYTES).
  - When occ>=n and the output register is empty or being accepted, load bytes 0..n-1 into the output register.
  - M_TKEEP = 2^n-1. M_SOP=1 if remaining==incl_len. M_TLAST=1 if n==remaining.
  - Pop n bytes, remaining-=n. On TLAST, return to HDR in the same cycle.
- Output register: M_* held stable while M_TVALID&&!M_TREADY.
- Latency: first payload beat is registered no earlier than the cycle after header latch.
- Zero-bubble: with a 100% valid/ready stream, a DATA_BYTES-aligned record streams one beat per cycle.
- End of file: eof_seen is set on the accepted S_TLAST beat.
  - In HDR with 0<occ<16 after all input: set ERR_TRUNC, go to ERROR, emit nothing.
  - In PAYLOAD with occ<n and eof_seen: emit the occ bytes with M_TLAST=1, set ERR_TRUNC, go to DRAIN.
  - HDR with occ==0 and eof_seen: clean end, go to DRAIN.
- DRAIN and ERROR: S_TREADY=0, M_TVALID=0 once the output register has been accepted. Both states are left only by reset.
- HDR fields hold until the next latch. Widths: remaining is 32-bit. occ is clog2(2*DATA_BYTES)+1 bits.
- Reset mid-operation: all state is cleared asynchronously, and any partial beat in the output register is discarded.

Test Plan:
- DATA_BYTES=16, SWAP=0; header {ts_sec=5, frac=7, incl=64, orig=64} + 64 payload bytes 0x00..0x3F -> HDR_VALID pulse, 4 beats all-ones TKEEP, M_SOP on beat 0, M_TLAST on beat 3, RECORD_CNT=1.
- Two back-to-back records incl=20 then incl=13, no padding -> record 1: beats TKEEP 0xFFFF then 0x000F. Record 2 starts at byte offset 36 and is emitted as a single beat, TKEEP 0x1FFF with M_SOP=M_TLAST=1. RECORD_CNT=2.
- SWAP=1, header bytes 00 00 00 05 … -> HDR_TS_SEC=5; same payload behaviour as the unswapped case.
- M_TREADY toggled 1-0-0-1 at random and S_TVALID gapped during a 100-byte record -> byte sequence intact, M_* stable while stalled, no duplicate or lost beats.
- incl_len=0 and incl_len=MAX_INCL_LEN+1 (separate runs) -> ERR_FORMAT=1, S_TREADY=0 thereafter, no output beats; recovers after RST_N pulse.
- File ends 10 bytes into a 64-byte payload (S_TLAST, TKEEP 0x03FF) -> one beat TKEEP 0x03FF with M_TLAST, ERR_TRUNC=1; DATA_BYTES=8 and 64 rerun of the first scenario gives the same byte sequence.
